// File: rtl/pulse_period_meter.sv
// Measures the rise-to-rise period and high time of an asynchronous pin signal in
// CLOCK cycles, raising a sticky TIMEOUT when no rising edge arrives within the counter range.
module pulse_period_meter #(
    parameter int WIDTH       = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             SIG_IN,
    output logic [WIDTH-1:0] PERIOD,
    output logic [WIDTH-1:0] HIGH_TIME,
    output logic             VALID,
    output logic             TIMEOUT,
    output logic             ACTIVE
);

    typedef enum logic {IDLE, MEASURE} state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_d_q, s_d_d;
    logic [WIDTH-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       hcnt_q, hcnt_d;
    logic [WIDTH-1:0]       period_q, period_d;
    logic [WIDTH-1:0]       high_q, high_d;
    logic                   valid_q, valid_d;
    logic                   timeout_q, timeout_d;
    logic                   s;
    logic                   rise;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], SIG_IN};
        s      = sync_q[SYNC_STAGES-1];
        s_d_d  = s;
        rise   = s & ~s_d_q;
    end

    // A rise always wins over the timeout; the counter leaves MEASURE before it can wrap.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (rise && ENABLE) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_ONE;
                    hcnt_d  = CNT_ONE;
                end
            end
            MEASURE: begin
                if (!ENABLE) begin
                    state_d = IDLE;
                end else if (rise) begin
                    period_d  = cnt_q;
                    high_d    = hcnt_q;
                    valid_d   = 1'b1;
                    timeout_d = 1'b0;
                    cnt_d     = CNT_ONE;
                    hcnt_d    = CNT_ONE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (s && (hcnt_q != CNT_MAX)) begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            s_d_q     <= 1'b0;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            s_d_q     <= s_d_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign PERIOD    = period_q;
    assign HIGH_TIME = high_q;
    assign VALID     = valid_q;
    assign TIMEOUT   = timeout_q;
    assign ACTIVE    = (state_q == MEASURE);

endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: a 24-bit and an 8-bit instance share one stimulus stream and
// are compared every cycle against a timestamp-based reference model, plus directed scenarios.
module tb_pulse_period_meter;

    localparam int SS   = 2;
    localparam int HIST = 100000;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        ENABLE;
    logic        SIG_IN;

    logic [23:0] period_big, high_big;
    logic        valid_big, timeout_big, active_big;
    logic [7:0]  period_sm, high_sm;
    logic        valid_sm, timeout_sm, active_sm;

    int n_vec    = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;
    int vcnt_big = 0;
    int vcnt_sm  = 0;

    always #5 CLOCK = ~CLOCK;

    pulse_period_meter #(.WIDTH(24), .SYNC_STAGES(SS)) dut_big (
        .CLOCK(CLOCK), .RESET(RESET), .ENABLE(ENABLE), .SIG_IN(SIG_IN),
        .PERIOD(period_big), .HIGH_TIME(high_big), .VALID(valid_big),
        .TIMEOUT(timeout_big), .ACTIVE(active_big)
    );

    pulse_period_meter #(.WIDTH(8), .SYNC_STAGES(SS)) dut_sm (
        .CLOCK(CLOCK), .RESET(RESET), .ENABLE(ENABLE), .SIG_IN(SIG_IN),
        .PERIOD(period_sm), .HIGH_TIME(high_sm), .VALID(valid_sm),
        .TIMEOUT(timeout_sm), .ACTIVE(active_sm)
    );

    // Reference model: the input history is kept per edge; period is the distance between
    // rise timestamps and high time is the number of high synchronized cycles between them.
    bit sig_hist [HIST];
    int edge_n     = 0;
    int reset_edge = 0;
    bit m_armed   [2];
    int m_last    [2];
    int m_period  [2];
    int m_high    [2];
    bit m_valid   [2];
    bit m_timeout [2];
    int m_max     [2] = '{(1 << 24) - 1, (1 << 8) - 1};

    function automatic bit s_at(input int j);
        int idx;
        idx = j - SS + 1;
        if (idx < 0 || idx <= reset_edge || idx >= HIST) return 1'b0;
        return sig_hist[idx];
    endfunction

    always @(posedge CLOCK) begin : ref_model
        int c;
        bit r;
        if (edge_n < HIST) sig_hist[edge_n] = SIG_IN;
        if (RESET) begin
            reset_edge = edge_n;
            for (int w = 0; w < 2; w++) begin
                m_armed[w]   = 1'b0;
                m_period[w]  = 0;
                m_high[w]    = 0;
                m_valid[w]   = 1'b0;
                m_timeout[w] = 1'b0;
            end
        end else begin
            c = edge_n - 1;
            r = s_at(c) && !s_at(c - 1);
            for (int w = 0; w < 2; w++) begin
                m_valid[w] = 1'b0;
                if (!m_armed[w]) begin
                    if (r && ENABLE) begin
                        m_armed[w] = 1'b1;
                        m_last[w]  = c;
                    end
                end else if (!ENABLE) begin
                    m_armed[w] = 1'b0;
                end else if (r) begin
                    m_period[w] = c - m_last[w];
                    m_high[w]   = 0;
                    for (int j = m_last[w]; j < c; j++) m_high[w] += int'(s_at(j));
                    m_valid[w]   = 1'b1;
                    m_timeout[w] = 1'b0;
                    m_last[w]    = c;
                end else if (c - m_last[w] == m_max[w]) begin
                    m_armed[w]   = 1'b0;
                    m_timeout[w] = 1'b1;
                end
            end
        end
        edge_n++;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    always @(negedge CLOCK) begin
        if (check_en) begin
            checkOutput("cycle_w24",
                64'({valid_big, active_big, timeout_big, period_big, high_big}),
                64'({m_valid[0], m_armed[0], m_timeout[0], m_period[0][23:0], m_high[0][23:0]}));
            checkOutput("cycle_w8",
                64'({valid_sm, active_sm, timeout_sm, period_sm, high_sm}),
                64'({m_valid[1], m_armed[1], m_timeout[1], m_period[1][7:0], m_high[1][7:0]}));
        end
    end

    always @(posedge CLOCK) begin
        #1;
        if (valid_big === 1'b1) vcnt_big++;
        if (valid_sm === 1'b1) vcnt_sm++;
    end

    // Each call spans exactly one rising edge, starting and ending on a falling edge.
    task automatic applyStimulus(input bit sig, input bit en, input bit rst);
        SIG_IN = sig;
        ENABLE = en;
        RESET  = rst;
        @(negedge CLOCK);
    endtask

    task automatic run_wave(input int period, input int high, input int nper, input bit en);
        for (int p = 0; p < nper; p++)
            for (int i = 0; i < period; i++)
                applyStimulus(i < high, en, 1'b0);
    endtask

    typedef struct {
        int period;
        int high;
        bit en;
        int exp_period;
        int exp_high;
    } vec_t;

    initial begin
        vec_t tbl[$];
        int   v0;
        int   lat;
        int   cyc;
        int   p;
        int   h;

        tbl.push_back('{8, 4, 1'b1, 8, 4});
        tbl.push_back('{2, 1, 1'b1, 2, 1});
        tbl.push_back('{3, 2, 1'b1, 3, 2});
        tbl.push_back('{16, 8, 1'b1, 16, 8});
        tbl.push_back('{10, 5, 1'b1, 10, 5});
        tbl.push_back('{7, 1, 1'b1, 7, 1});
        tbl.push_back('{37, 30, 1'b1, 37, 30});
        tbl.push_back('{100, 1, 1'b1, 100, 1});
        tbl.push_back('{254, 127, 1'b1, 254, 127});
        tbl.push_back('{50, 25, 1'b0, 254, 127});
        tbl.push_back('{12, 6, 1'b1, 12, 6});

        RESET  = 1'b1;
        ENABLE = 1'b0;
        SIG_IN = 1'b0;
        @(negedge CLOCK);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
        check_en = 1'b1;
        checkOutput("reset_period", period_big, 0);
        checkOutput("reset_high", high_big, 0);
        checkOutput("reset_valid", valid_big, 0);
        checkOutput("reset_timeout", timeout_big, 0);
        checkOutput("reset_active", active_big, 0);

        // First rise after reset only arms; then 8-cycle square wave.
        v0 = vcnt_big;
        run_wave(8, 4, 1, 1'b1);
        checkOutput("sq8_arm_no_valid", vcnt_big - v0, 0);
        run_wave(8, 4, 4, 1'b1);
        checkOutput("sq8_valid_count", vcnt_big - v0, 4);
        checkOutput("sq8_period", period_big, 8);
        checkOutput("sq8_high", high_big, 4);

        // 1000/250 wave: edge-to-VALID latency measured on the second rise.
        run_wave(1000, 250, 1, 1'b1);
        lat = -1;
        for (int i = 1; i <= 250; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            if (lat < 0 && valid_big === 1'b1) lat = i;
        end
        repeat (750) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("latency_edges", lat, SS + 1);
        checkOutput("p1000_period", period_big, 1000);
        checkOutput("p1000_high", high_big, 250);

        for (int k = 0; k < tbl.size(); k++) begin
            run_wave(tbl[k].period, tbl[k].high, 3, tbl[k].en);
            repeat (4) applyStimulus(1'b0, tbl[k].en, 1'b0);
            checkOutput("tbl_period_w24", period_big, tbl[k].exp_period);
            checkOutput("tbl_high_w24", high_big, tbl[k].exp_high);
            checkOutput("tbl_period_w8", period_sm, tbl[k].exp_period);
            checkOutput("tbl_high_w8", high_sm, tbl[k].exp_high);
        end

        // 8-bit timeout: one rise then hold low until the 255-cycle limit expires.
        run_wave(12, 6, 3, 1'b1);
        cyc = -1;
        for (int i = 1; i <= 300; i++) begin
            applyStimulus(i <= 6, 1'b1, 1'b0);
            if (cyc < 0 && timeout_sm === 1'b1) cyc = i;
        end
        checkOutput("timeout_edge", cyc, 258);
        checkOutput("timeout_flag", timeout_sm, 1);
        checkOutput("timeout_active", active_sm, 0);
        checkOutput("timeout_period_held", period_sm, 12);
        checkOutput("timeout_w24_clear", timeout_big, 0);
        v0 = vcnt_sm;
        run_wave(20, 10, 1, 1'b1);
        checkOutput("timeout_sticky_after_arm", timeout_sm, 1);
        run_wave(20, 10, 2, 1'b1);
        checkOutput("timeout_cleared", timeout_sm, 0);
        checkOutput("after_timeout_period", period_sm, 20);
        checkOutput("after_timeout_valids", vcnt_sm - v0, 2);

        // Rise exactly at the counter limit still produces a VALID.
        applyStimulus(1'b0, 1'b1, 1'b1);
        v0 = vcnt_sm;
        run_wave(255, 4, 2, 1'b1);
        checkOutput("max_valids", vcnt_sm - v0, 1);
        checkOutput("max_period", period_sm, 255);
        checkOutput("max_high", high_sm, 4);
        checkOutput("max_no_timeout", timeout_sm, 0);

        // Reset during the low phase of a period-16 wave.
        run_wave(16, 8, 2, 1'b1);
        for (int i = 0; i < 12; i++) applyStimulus(i < 8, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("midreset_period", period_big, 0);
        checkOutput("midreset_high", high_big, 0);
        checkOutput("midreset_timeout", timeout_big, 0);
        checkOutput("midreset_active", active_big, 0);
        checkOutput("midreset_period_w8", period_sm, 0);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
        v0 = vcnt_big;
        run_wave(16, 8, 1, 1'b1);
        checkOutput("midreset_first_rise", vcnt_big - v0, 0);
        run_wave(16, 8, 1, 1'b1);
        checkOutput("midreset_second_rise", vcnt_big - v0, 1);
        checkOutput("midreset_period16", period_big, 16);

        // ENABLE dropped for 40 cycles of a period-10 wave.
        run_wave(10, 5, 2, 1'b1);
        v0 = vcnt_big;
        run_wave(10, 5, 4, 1'b0);
        checkOutput("disabled_no_valid", vcnt_big - v0, 0);
        checkOutput("disabled_period_held", period_big, 10);
        checkOutput("disabled_idle", active_big, 0);
        run_wave(10, 5, 1, 1'b1);
        checkOutput("reenable_arm_only", vcnt_big - v0, 0);
        checkOutput("reenable_active", active_big, 1);
        run_wave(10, 5, 2, 1'b1);
        checkOutput("reenable_valids", vcnt_big - v0, 2);
        checkOutput("reenable_period", period_big, 10);

        // Randomized segments, checked every cycle by the reference model.
        for (int seg = 0; seg < 40; seg++) begin
            case ($urandom_range(0, 19))
                0: applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1'b1);
                1: repeat ($urandom_range(240, 270)) applyStimulus(1'b0, 1'b1, 1'b0);
                default: begin
                    p = $urandom_range(2, 60);
                    h = $urandom_range(1, p - 1);
                    run_wave(p, h, $urandom_range(1, 4), $urandom_range(0, 9) != 0);
                end
            endcase
        end

        repeat (5) applyStimulus(1'b0, 1'b1, 1'b0);
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
